// File: rtl/ravan_pkg.sv
// rtl/ravan_pkg.sv - shared types and constants for the RAVAN cipher core
package ravan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      ENC = 1'b0,
      DEC = 1'b1
   } mode_e;

   localparam logic [63:0] DEFAULT_SEED = 64'hffda_1234_daae_a339;

   // Feedback taps, counted down from the MSB
   localparam int TAP_HI = 1;
   localparam int TAP_LO = 3;

endpackage

// File: rtl/ravan_mask_lfsr.sv
// rtl/ravan_mask_lfsr.sv - per-block whitening mask generator
module ravan_mask_lfsr
   import ravan_pkg::*;
#(
   parameter int               WIDTH = 64,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= SEED;
      end else if (advance) begin
         value <= {value[WIDTH-2:0], value[WIDTH-TAP_HI] ^ value[WIDTH-TAP_LO]};
      end
   end

endmodule

// File: rtl/ravan_cipher_core.sv
// rtl/ravan_cipher_core.sv - iterative RAVAN encrypt/decrypt engine, one key-slice step per clock
module ravan_cipher_core
   import ravan_pkg::*;
#(
   parameter int                DATA_W    = 64,
   parameter int                NSLICE    = 8,
   parameter int                ROUNDS    = 21,
   parameter int                ROT       = 7,
   parameter logic [DATA_W-1:0] MASK_SEED = DATA_W'(DEFAULT_SEED)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mode,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [NSLICE*DATA_W-1:0] key,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     busy
);

   localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam int SLC_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);
   localparam logic [SLC_W-1:0] SLC_LAST = SLC_W'(NSLICE - 1);

   state_e            state, state_nxt;
   mode_e             mode_r;
   logic [DATA_W-1:0] key_r [NSLICE];
   logic [DATA_W-1:0] m_r, x_r, x_next, lfsr_value, k_s, sum, t;
   logic [RND_W-1:0]  round_cnt;
   logic [SLC_W-1:0]  slice_cnt, slice_idx;
   logic              accept, last_step;

   assign accept    = in_valid && (state == IDLE);
   assign last_step = (state == RUN) && (round_cnt == RND_LAST) && (slice_cnt == SLC_LAST);

   ravan_mask_lfsr #(
      .WIDTH (DATA_W),
      .SEED  (MASK_SEED)
   ) u_mask_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (accept),
      .value   (lfsr_value)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state == RUN) || (state == DONE);
   end

   // Decrypt walks the slices in reverse so each step undoes the matching encrypt step
   always_comb begin
      slice_idx = (mode_r == DEC) ? (SLC_LAST - slice_cnt) : slice_cnt;
      k_s       = key_r[slice_idx];
      sum       = x_r + k_s;
      t         = x_r ^ m_r;
      if (mode_r == DEC) x_next = {t[ROT-1:0], t[DATA_W-1:ROT]} - k_s;
      else               x_next = {sum[DATA_W-ROT-1:0], sum[DATA_W-1:DATA_W-ROT]} ^ m_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSLICE; i++) key_r[i] <= '0;
         mode_r    <= ENC;
         m_r       <= '0;
         x_r       <= '0;
         round_cnt <= '0;
         slice_cnt <= '0;
         out_data  <= '0;
      end else if (accept) begin
         for (int i = 0; i < NSLICE; i++) key_r[i] <= key[i*DATA_W +: DATA_W];
         mode_r    <= mode_e'(mode);
         m_r       <= lfsr_value;
         x_r       <= in_data ^ lfsr_value;
         round_cnt <= '0;
         slice_cnt <= '0;
      end else if (state == RUN) begin
         x_r <= x_next;
         if (slice_cnt == SLC_LAST) begin
            slice_cnt <= '0;
            round_cnt <= round_cnt + 1'b1;
         end else begin
            slice_cnt <= slice_cnt + 1'b1;
         end
         if (last_step) out_data <= x_next ^ m_r;
      end
   end

endmodule
